// File: rtl/multi_edgedet.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : multi_edgedet
//  Brief    : Multi-channel edge detector. Each asynchronous input passes
//             through a synchroniser chain and a consecutive-sample glitch
//             filter. The block then issues one-cycle rise/fall pulses and
//             sets mode-selected sticky event flags, which are ORed into irq.
//  Revision : 1.0  initial release
// ============================================================================
module multi_edgedet #(
    parameter int   NCH         = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = 1,
    parameter logic RST_LEVEL   = 1'b0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [NCH-1:0]   sig_in,
    input  logic [2*NCH-1:0] mode,
    input  logic [NCH-1:0]   clear_evt,
    output logic [NCH-1:0]   level,
    output logic [NCH-1:0]   rise,
    output logic [NCH-1:0]   fall,
    output logic [NCH-1:0]   evt_pending,
    output logic             irq
);

    // The filter counter only needs to reach FILT_LEN-1. It keeps at least
    // one bit so that FILT_LEN=1 still gives a legal vector.
    localparam int                 c_cnt_w   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILT_LEN - 1);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_cnt_w-1:0]     r_cnt;
        logic                   r_level;
        logic                   r_rise;
        logic                   r_fall;
        logic                   r_evt;
        logic                   w_s;
        logic                   w_accept;
        logic                   w_rise_nxt;
        logic                   w_fall_nxt;
        logic                   w_set;

        // Synchronised sample is the last flop of the chain
        assign w_s        = r_sync[SYNC_STAGES-1];
        // A change is accepted on the FILT_LEN-th consecutive differing sample
        assign w_accept   = (w_s != r_level) && (r_cnt == c_cnt_max);
        assign w_rise_nxt = w_accept & w_s;
        assign w_fall_nxt = w_accept & ~w_s;
        // mode gates only flag setting, never the pulses themselves
        assign w_set      = (w_rise_nxt & mode[2*i]) | (w_fall_nxt & mode[2*i+1]);

        // Synchroniser shift register; stage 1 samples the raw input
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                r_sync <= {SYNC_STAGES{RST_LEVEL}};
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in[i]};
            end
        end

        // Glitch filter: count consecutive differing samples, then adopt the new level
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                r_level <= RST_LEVEL;
                r_cnt   <= '0;
            end else if (w_s == r_level) begin
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_level <= w_s;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end

        // Edge pulses registered alongside the level; sticky flag where set beats clear
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                r_evt  <= 1'b0;
            end else begin
                r_rise <= w_rise_nxt;
                r_fall <= w_fall_nxt;
                r_evt  <= w_set | (r_evt & ~clear_evt[i]);
            end
        end

        assign level[i]       = r_level;
        assign rise[i]        = r_rise;
        assign fall[i]        = r_fall;
        assign evt_pending[i] = r_evt;
    end

    assign irq = |evt_pending;

endmodule
`default_nettype wire

// File: tb/tb_multi_edgedet.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_multi_edgedet
//  Brief    : Self-checking bench for multi_edgedet. Two instances are driven
//             from shared inputs: instance A uses the default parameters, and
//             instance B uses 3 sync stages, FILT_LEN=3 and RST_LEVEL=1.
//             Outputs are compared against a sample-history reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_edgedet;

    localparam int   NCH  = 4;
    localparam int   MW   = 2 * NCH;
    localparam int   SS_A = 2;
    localparam int   FL_A = 1;
    localparam logic RL_A = 1'b0;
    localparam int   SS_B = 3;
    localparam int   FL_B = 3;
    localparam logic RL_B = 1'b1;

    logic            clk;
    logic            n_rst;
    logic [NCH-1:0]  sig_in;
    logic [MW-1:0]   mode;
    logic [NCH-1:0]  clear_evt;

    logic [NCH-1:0]  lvl_o  [2];
    logic [NCH-1:0]  rise_o [2];
    logic [NCH-1:0]  fall_o [2];
    logic [NCH-1:0]  evt_o  [2];
    logic            irq_o  [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: every input sample since reset, plus the expected outputs
    logic [NCH-1:0]  samp [$];
    logic [NCH-1:0]  m_lvl  [2];
    logic [NCH-1:0]  m_rise [2];
    logic [NCH-1:0]  m_fall [2];
    logic [NCH-1:0]  m_evt  [2];
    int              streak [2][NCH];
    int              hold   [NCH];

    multi_edgedet #(
        .NCH(NCH), .SYNC_STAGES(SS_A), .FILT_LEN(FL_A), .RST_LEVEL(RL_A)
    ) u_dut_a (
        .clk(clk), .n_rst(n_rst), .sig_in(sig_in), .mode(mode), .clear_evt(clear_evt),
        .level(lvl_o[0]), .rise(rise_o[0]), .fall(fall_o[0]),
        .evt_pending(evt_o[0]), .irq(irq_o[0])
    );

    multi_edgedet #(
        .NCH(NCH), .SYNC_STAGES(SS_B), .FILT_LEN(FL_B), .RST_LEVEL(RL_B)
    ) u_dut_b (
        .clk(clk), .n_rst(n_rst), .sig_in(sig_in), .mode(mode), .clear_evt(clear_evt),
        .level(lvl_o[1]), .rise(rise_o[1]), .fall(fall_o[1]),
        .evt_pending(evt_o[1]), .irq(irq_o[1])
    );

    // 10 ns system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts, and reports any mismatch
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Return the model to its reset state
    task automatic model_reset();
        samp.delete();
        for (int d = 0; d < 2; d++) begin
            m_lvl[d]  = ((d == 0) ? RL_A : RL_B) ? {NCH{1'b1}} : {NCH{1'b0}};
            m_rise[d] = '0;
            m_fall[d] = '0;
            m_evt[d]  = '0;
            for (int c = 0; c < NCH; c++) streak[d][c] = 0;
        end
    endtask

    // Predict the effect of one rising edge with the currently driven inputs.
    // The synchronised value seen at edge k is the input sampled SS edges earlier.
    task automatic model_step();
        logic [NCH-1:0] past;
        int             ss;
        int             fl;
        logic           rl;
        logic           s;
        logic           acc;
        logic           setb;
        for (int d = 0; d < 2; d++) begin
            ss = (d == 0) ? SS_A : SS_B;
            fl = (d == 0) ? FL_A : FL_B;
            rl = (d == 0) ? RL_A : RL_B;
            past = (samp.size() >= ss) ? samp[samp.size() - ss] : {NCH{rl}};
            for (int c = 0; c < NCH; c++) begin
                s   = past[c];
                acc = 1'b0;
                if (s != m_lvl[d][c]) begin
                    streak[d][c]++;
                    if (streak[d][c] >= fl) begin
                        acc          = 1'b1;
                        streak[d][c] = 0;
                        m_lvl[d][c]  = s;
                    end
                end else begin
                    streak[d][c] = 0;
                end
                m_rise[d][c] = acc & s;
                m_fall[d][c] = acc & ~s;
                setb = (m_rise[d][c] & mode[2*c]) | (m_fall[d][c] & mode[2*c+1]);
                m_evt[d][c] = setb | (m_evt[d][c] & ~clear_evt[c]);
            end
        end
        samp.push_back(sig_in);
    endtask

    // Compare all outputs of both instances with the model
    task automatic check_all();
        string t;
        for (int d = 0; d < 2; d++) begin
            t = (d == 0) ? "A" : "B";
            chk({t, ".level"}, 32'(lvl_o[d]),  32'(m_lvl[d]));
            chk({t, ".rise"},  32'(rise_o[d]), 32'(m_rise[d]));
            chk({t, ".fall"},  32'(fall_o[d]), 32'(m_fall[d]));
            chk({t, ".evt"},   32'(evt_o[d]),  32'(m_evt[d]));
            chk({t, ".irq"},   32'(irq_o[d]),  32'(|m_evt[d]));
        end
    endtask

    // Advance one clock: predict the next edge, then check at the falling edge
    task automatic tick();
        if (n_rst) model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        n_rst     = 1'b0;
        sig_in    = '0;
        mode      = '1;
        clear_evt = '0;
        model_reset();
        for (int c = 0; c < NCH; c++) hold[c] = 1;

        // Reset state
        tick();
        tick();

        // HCLK-like square wave on channel 0 with a 100 ns period, all modes 'both'
        n_rst = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            sig_in[0] = ((cyc / 5) % 2) != 0;
            tick();
        end

        // Randomised per-channel hold times of 1..6 cycles; this exercises the
        // glitch rejection in instance B and set/clear collisions
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    sig_in[c] = ~sig_in[c];
                    hold[c]   = int'($urandom_range(6, 1));
                end
            end
            if ((cyc % 50) == 0) mode = MW'($urandom);
            clear_evt = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
            tick();
        end
        clear_evt = '0;

        // Mid-cycle asynchronous reset with all inputs high
        sig_in = '1;
        mode   = '1;
        tick();
        #2;
        n_rst = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_async_rise", 32'(rise_o[0]), 32'(0));
        chk("rst_async_evt",  32'(evt_o[0]),  32'(0));
        chk("rst_async_lvlB", 32'(lvl_o[1]),  32'({NCH{1'b1}}));
        tick();
        n_rst = 1'b1;
        // Instance A: one accept on the third edge after release; B already sits at 1
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("lat_rise_a", 32'(rise_o[0]), (e == 3) ? 32'({NCH{1'b1}}) : 32'(0));
            chk("lat_rise_b", 32'(rise_o[1]), 32'(0));
        end

        // All channels toggled together with mixed modes: ch3 both, ch2 fall, ch1 rise, ch0 none
        for (int k = 0; k < 4; k++) tick();
        clear_evt = '1;
        tick();
        clear_evt = '0;
        mode = 8'b11_10_01_00;
        sig_in = '0;
        for (int k = 0; k < 8; k++) tick();
        chk("mix_fall_evt_a", 32'(evt_o[0]), 32'(4'b1100));
        chk("mix_fall_evt_b", 32'(evt_o[1]), 32'(4'b1100));
        sig_in = '1;
        for (int k = 0; k < 8; k++) tick();
        chk("mix_evt_a", 32'(evt_o[0]), 32'(4'b1110));
        chk("mix_evt_b", 32'(evt_o[1]), 32'(4'b1110));
        chk("mix_irq_a", 32'(irq_o[0]), 32'(1));

        // Clear everything and confirm that irq drops
        clear_evt = '1;
        tick();
        clear_evt = '0;
        tick();
        chk("clr_irq_a", 32'(irq_o[0]), 32'(0));
        chk("clr_irq_b", 32'(irq_o[1]), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
